// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if -- groups the hazard, cache-handshake and pipeline-control
// signals of pipeline_ctrl.
//   master : the pipeline/cache side (drives hazard info and cache responses)
//   slave  : pipeline_ctrl (drives request gates, delivered data, loads, flushes)
// Parameter CNT_W sets the width of each performance counter in perf_cnt.
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
  // hazard inputs
  logic [4:0]         id_rs1;
  logic [4:0]         id_rs2;
  logic [1:0]         id_use;
  logic               idex_memread;
  logic [4:0]         idex_rd;
  logic               exmem_memread;
  logic [4:0]         exmem_rd;
  logic               br_redirect;
  // cache handshake
  logic               imem_resp;
  logic [31:0]        imem_rdata;
  logic               dmem_req;
  logic               dmem_resp;
  logic [31:0]        dmem_rdata;
  // controller outputs
  logic               imem_req_en;
  logic               dmem_req_en;
  logic [31:0]        if_instr;
  logic [31:0]        mem_rdata;
  logic [4:0]         stage_load;
  logic [1:0]         flush;
  logic [3*CNT_W-1:0] perf_cnt;

  modport master (
    output id_rs1, id_rs2, id_use, idex_memread, idex_rd, exmem_memread,
           exmem_rd, br_redirect, imem_resp, imem_rdata, dmem_req,
           dmem_resp, dmem_rdata,
    input  imem_req_en, dmem_req_en, if_instr, mem_rdata, stage_load,
           flush, perf_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use, idex_memread, idex_rd, exmem_memread,
           exmem_rd, br_redirect, imem_resp, imem_rdata, dmem_req,
           dmem_resp, dmem_rdata,
    output imem_req_en, dmem_req_en, if_instr, mem_rdata, stage_load,
           flush, perf_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- 5-stage pipeline stall/flush controller.
// Detects load-use hazards, freezes the pipe while either cache is pending,
// and holds whichever cache response arrived first until the other one lands
// so both are delivered in the same advance cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : pipeline_ctrl_if.slave (hazard inputs, cache handshake, stage
//          loads {pc,ifid,idex,exmem,memwb}, flushes {idex,ifid}, perf_cnt)
// Optional feature: define PIPELINE_CTRL_PERF_EN to build the saturating
// performance counters {flush_cnt, mem_cnt, lu_cnt}; otherwise perf_cnt is 0.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {RUN = 2'd0, I_HELD = 2'd1, D_HELD = 2'd2} state_t;

  state_t      state;
  logic [31:0] i_hold;
  logic [31:0] d_hold;

  logic rs1_hit_x, rs2_hit_x, rs1_hit_m, rs2_hit_m;
  logic lu, i_ok, d_ok, adv;

  // Loads forward only from MEM/WB, so a consumer must wait while the load
  // sits in either ID/EX or EX/MEM. x0 is never a real dependency.
  assign rs1_hit_x = bus.id_use[0] && (bus.id_rs1 == bus.idex_rd);
  assign rs2_hit_x = bus.id_use[1] && (bus.id_rs2 == bus.idex_rd);
  assign rs1_hit_m = bus.id_use[0] && (bus.id_rs1 == bus.exmem_rd);
  assign rs2_hit_m = bus.id_use[1] && (bus.id_rs2 == bus.exmem_rd);
  assign lu = (bus.idex_memread  && (bus.idex_rd  != 5'd0) && (rs1_hit_x || rs2_hit_x)) ||
              (bus.exmem_memread && (bus.exmem_rd != 5'd0) && (rs1_hit_m || rs2_hit_m));

  assign i_ok = bus.imem_resp;
  assign d_ok = !bus.dmem_req || bus.dmem_resp;

  // In a held state only the missing side is awaited.
  always_comb begin
    adv = 1'b0;
    unique case (state)
      RUN:     adv = i_ok && d_ok;
      I_HELD:  adv = bus.dmem_resp;
      D_HELD:  adv = bus.imem_resp;
      default: adv = 1'b0;
    endcase
  end

  assign bus.imem_req_en = (state != I_HELD);
  assign bus.dmem_req_en = bus.dmem_req && (state != D_HELD);
  assign bus.if_instr    = (state == I_HELD) ? i_hold : bus.imem_rdata;
  assign bus.mem_rdata   = (state == D_HELD) ? d_hold : bus.dmem_rdata;

  // Redirect and load-use are only acted on in advance cycles.
  always_comb begin
    bus.stage_load = 5'b00000;
    bus.flush      = 2'b00;
    if (adv) begin
      if (bus.br_redirect) begin
        bus.stage_load = 5'b11111;
        bus.flush      = 2'b11;
      end else if (lu) begin
        bus.stage_load = 5'b00111;
        bus.flush      = 2'b10;
      end else begin
        bus.stage_load = 5'b11111;
        bus.flush      = 2'b00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (i_ok && !d_ok) begin
            i_hold <= bus.imem_rdata;
            state  <= I_HELD;
          end else if (!i_ok && bus.dmem_req && bus.dmem_resp) begin
            d_hold <= bus.dmem_rdata;
            state  <= D_HELD;
          end
        end
        I_HELD:  if (bus.dmem_resp) state <= RUN;
        D_HELD:  if (bus.imem_resp) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [CNT_W-1:0] lu_cnt, mem_cnt, flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_cnt    <= '0;
      mem_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      if (adv && lu && !bus.br_redirect && !(&lu_cnt)) lu_cnt    <= lu_cnt + CNT_W'(1);
      if (!adv && !(&mem_cnt))                         mem_cnt   <= mem_cnt + CNT_W'(1);
      if (adv && bus.br_redirect && !(&flush_cnt))     flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.perf_cnt = {flush_cnt, mem_cnt, lu_cnt};
`else
  assign bus.perf_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) ifc ();
  pipeline_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  int n_chk  = 0;
  int n_fail = 0;

  logic [CNT_W-1:0] lu_m, mem_m, flush_m;

  typedef struct {
    logic [1:0] id_use;
    logic [4:0] rs1, rs2;
    logic       xm;
    logic [4:0] xrd;
    logic       mm;
    logic [4:0] mrd;
    logic       br, ir, dq, dr;
    logic [4:0] sl;
    logic [1:0] fl;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [127:0] perf_exp();
`ifdef PIPELINE_CTRL_PERF_EN
    return 128'({flush_m, mem_m, lu_m});
`else
    return 128'(0);
`endif
  endfunction

  task automatic idle_inputs();
    ifc.id_rs1 = 5'd0; ifc.id_rs2 = 5'd0; ifc.id_use = 2'b00;
    ifc.idex_memread = 1'b0; ifc.idex_rd = 5'd0;
    ifc.exmem_memread = 1'b0; ifc.exmem_rd = 5'd0;
    ifc.br_redirect = 1'b0;
    ifc.imem_resp = 1'b1; ifc.imem_rdata = 32'h0;
    ifc.dmem_req = 1'b0; ifc.dmem_resp = 1'b0; ifc.dmem_rdata = 32'h0;
  endtask

  // Checks loads/flushes and perf counters for the current cycle, updates the
  // counter model from the expected outcome, then moves to the next cycle.
  task automatic cyc(input string name, input logic [4:0] sl, input logic [1:0] fl);
    #3;
    chk({name, ".stage_load"}, 128'(ifc.stage_load), 128'(sl));
    chk({name, ".flush"}, 128'(ifc.flush), 128'(fl));
    chk({name, ".perf_cnt"}, 128'(ifc.perf_cnt), perf_exp());
    if (sl == 5'b00000)  mem_m   = sat_inc(mem_m);
    else if (fl == 2'b11) flush_m = sat_inc(flush_m);
    else if (fl == 2'b10) lu_m    = sat_inc(lu_m);
    @(posedge clk); #1;
  endtask

  vec_t vt [14];

  initial begin
    lu_m = '0; mem_m = '0; flush_m = '0;
    //         use    rs1 rs2 xm xrd mm mrd br ir dq dr  sl        fl
    vt[0]  = '{2'b11, 1,  2,  1, 3,  0, 0,  0, 1, 0, 0, 5'b11111, 2'b00}; // no hazard
    vt[1]  = '{2'b01, 5,  0,  1, 5,  0, 0,  0, 1, 0, 0, 5'b00111, 2'b10}; // load in ID/EX
    vt[2]  = '{2'b01, 5,  0,  0, 0,  1, 5,  0, 1, 0, 0, 5'b00111, 2'b10}; // load in EX/MEM
    vt[3]  = '{2'b01, 5,  0,  0, 0,  0, 5,  0, 1, 0, 0, 5'b11111, 2'b00}; // load retired
    vt[4]  = '{2'b01, 0,  0,  1, 0,  0, 0,  0, 1, 0, 0, 5'b11111, 2'b00}; // rd = x0
    vt[5]  = '{2'b01, 1,  5,  1, 5,  0, 0,  0, 1, 0, 0, 5'b11111, 2'b00}; // rs2 not used
    vt[6]  = '{2'b10, 1,  5,  1, 5,  0, 0,  0, 1, 0, 0, 5'b00111, 2'b10}; // rs2 used
    vt[7]  = '{2'b11, 5,  5,  0, 5,  0, 0,  0, 1, 0, 0, 5'b11111, 2'b00}; // not a load
    vt[8]  = '{2'b11, 0,  0,  0, 0,  1, 0,  0, 1, 0, 0, 5'b11111, 2'b00}; // exmem x0
    vt[9]  = '{2'b01, 5,  0,  1, 5,  0, 0,  1, 1, 0, 0, 5'b11111, 2'b11}; // redirect beats lu
    vt[10] = '{2'b00, 0,  0,  0, 0,  0, 0,  1, 1, 0, 0, 5'b11111, 2'b11}; // redirect
    vt[11] = '{2'b01, 5,  0,  1, 5,  0, 0,  1, 0, 0, 0, 5'b00000, 2'b00}; // freeze, ifetch miss
    vt[12] = '{2'b01, 7,  0,  1, 7,  0, 0,  1, 0, 1, 0, 5'b00000, 2'b00}; // freeze, both miss
    vt[13] = '{2'b10, 0,  9,  0, 0,  1, 9,  0, 1, 1, 1, 5'b00111, 2'b10}; // dcache hit + lu

    // reset state
    idle_inputs();
    ifc.imem_resp = 1'b0;
    #12;
    chk("rst.imem_req_en", 128'(ifc.imem_req_en), 128'(1));
    chk("rst.dmem_req_en", 128'(ifc.dmem_req_en), 128'(0));
    chk("rst.stage_load", 128'(ifc.stage_load), 128'(0));
    chk("rst.perf_cnt", 128'(ifc.perf_cnt), 128'(0));
    ifc.imem_resp = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;

    // table vectors, all of which leave the FSM in RUN
    for (int i = 0; i < 14; i++) begin
      ifc.id_use = vt[i].id_use; ifc.id_rs1 = vt[i].rs1; ifc.id_rs2 = vt[i].rs2;
      ifc.idex_memread = vt[i].xm; ifc.idex_rd = vt[i].xrd;
      ifc.exmem_memread = vt[i].mm; ifc.exmem_rd = vt[i].mrd;
      ifc.br_redirect = vt[i].br; ifc.imem_resp = vt[i].ir;
      ifc.dmem_req = vt[i].dq; ifc.dmem_resp = vt[i].dr;
      ifc.imem_rdata = 32'hA000_0000 + 32'(i);
      ifc.dmem_rdata = 32'hB000_0000 + 32'(i);
      #1;
      chk($sformatf("vec%0d.if_instr", i), 128'(ifc.if_instr), 128'(32'hA000_0000 + 32'(i)));
      chk($sformatf("vec%0d.mem_rdata", i), 128'(ifc.mem_rdata), 128'(32'hB000_0000 + 32'(i)));
      chk($sformatf("vec%0d.imem_req_en", i), 128'(ifc.imem_req_en), 128'(1));
      chk($sformatf("vec%0d.dmem_req_en", i), 128'(ifc.dmem_req_en), 128'(vt[i].dq));
      cyc($sformatf("vec%0d", i), vt[i].sl, vt[i].fl);
    end

    // fetch returns first, data later: I_HELD for two cycles
    idle_inputs();
    ifc.imem_rdata = 32'h00A0_0093; ifc.dmem_req = 1'b1;
    cyc("ih.c1", 5'b00000, 2'b00);
    ifc.imem_resp = 1'b0; ifc.imem_rdata = 32'h1111_1111;
    ifc.br_redirect = 1'b1;  // ignored while frozen
    #1;
    chk("ih.c2.imem_req_en", 128'(ifc.imem_req_en), 128'(0));
    chk("ih.c2.if_instr", 128'(ifc.if_instr), 128'(32'h00A0_0093));
    cyc("ih.c2", 5'b00000, 2'b00);
    ifc.br_redirect = 1'b0;
    ifc.dmem_resp = 1'b1; ifc.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ih.c3.imem_req_en", 128'(ifc.imem_req_en), 128'(0));
    chk("ih.c3.if_instr", 128'(ifc.if_instr), 128'(32'h00A0_0093));
    chk("ih.c3.mem_rdata", 128'(ifc.mem_rdata), 128'(32'hDEAD_BEEF));
    cyc("ih.c3", 5'b11111, 2'b00);
    idle_inputs();
    ifc.imem_rdata = 32'h2222_2222;
    #1;
    chk("ih.c4.imem_req_en", 128'(ifc.imem_req_en), 128'(1));
    chk("ih.c4.if_instr", 128'(ifc.if_instr), 128'(32'h2222_2222));
    cyc("ih.c4", 5'b11111, 2'b00);

    // data returns first, fetch at cycle 4: D_HELD
    idle_inputs();
    ifc.imem_resp = 1'b0; ifc.dmem_req = 1'b1; ifc.dmem_resp = 1'b1;
    ifc.dmem_rdata = 32'h1234_5678;
    cyc("dh.c1", 5'b00000, 2'b00);
    ifc.dmem_resp = 1'b0; ifc.dmem_rdata = 32'h0;
    for (int c = 2; c <= 3; c++) begin
      #1;
      chk($sformatf("dh.c%0d.dmem_req_en", c), 128'(ifc.dmem_req_en), 128'(0));
      chk($sformatf("dh.c%0d.mem_rdata", c), 128'(ifc.mem_rdata), 128'(32'h1234_5678));
      cyc($sformatf("dh.c%0d", c), 5'b00000, 2'b00);
    end
    ifc.imem_resp = 1'b1; ifc.imem_rdata = 32'h4444_4444;
    #1;
    chk("dh.c4.mem_rdata", 128'(ifc.mem_rdata), 128'(32'h1234_5678));
    chk("dh.c4.if_instr", 128'(ifc.if_instr), 128'(32'h4444_4444));
    cyc("dh.c4", 5'b11111, 2'b00);

    // reset while in I_HELD
    idle_inputs();
    ifc.imem_rdata = 32'h5555_5555; ifc.dmem_req = 1'b1;
    cyc("rh.c1", 5'b00000, 2'b00);
    ifc.imem_resp = 1'b0; ifc.imem_rdata = 32'h3333_3333;
    #1;
    chk("rh.held.imem_req_en", 128'(ifc.imem_req_en), 128'(0));
    #1 rst = 1'b0;
    #1;
    lu_m = '0; mem_m = '0; flush_m = '0;
    chk("rh.imem_req_en", 128'(ifc.imem_req_en), 128'(1));
    chk("rh.if_instr", 128'(ifc.if_instr), 128'(32'h3333_3333));
    chk("rh.perf_cnt", 128'(ifc.perf_cnt), 128'(0));
    idle_inputs();
    ifc.imem_rdata = 32'h6666_6666;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rh.after.if_instr", 128'(ifc.if_instr), 128'(32'h6666_6666));
    cyc("rh.after", 5'b11111, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, width of each performance counter.
REQ-002 clk  in  1  sole clock; all flops rising-edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 id_rs1  in  5  rs1 index of instruction in ID.
REQ-005 id_rs2  in  5  rs2 index of instruction in ID.
REQ-006 id_use  in  2  bit0: ID reads rs1; bit1: ID reads rs2.
REQ-007 idex_memread  in  1  ID/EX holds a load.
REQ-008 idex_rd  in  5  ID/EX destination register.
REQ-009 exmem_memread  in  1  EX/MEM holds a load.
REQ-010 exmem_rd  in  5  EX/MEM destination register.
REQ-011 br_redirect  in  1  EX resolved a taken branch or jump.
REQ-012 imem_resp  in  1  icache response valid.
REQ-013 imem_rdata  in  32  icache read data.
REQ-014 dmem_req  in  1  MEM stage requests read or write.
REQ-015 dmem_resp  in  1  dcache response valid.
REQ-016 dmem_rdata  in  32  dcache read data.
REQ-017 imem_req_en  out  1  gate on fetch request to icache.
REQ-018 dmem_req_en  out  1  gate on MEM request to dcache.
REQ-019 if_instr  out  32  instruction delivered to IF/ID.
REQ-020 mem_rdata  out  32  load data delivered to MEM/WB.
REQ-021 stage_load  out  5  {pc, ifid, idex, exmem, memwb} load enables, bit4 = pc.
REQ-022 flush  out  2  bit1: bubble into ID/EX; bit0: bubble into IF/ID.
REQ-023 perf_cnt  out  3*CNT_W  {flush_cnt, mem_cnt, lu_cnt}, lu_cnt in LSBs.

Function
REQ-024 lu SHALL be 1 when any of the following holds: idex_memread, idex_rd!=0, and idex_rd matches an ID source enabled by id_use; or exmem_memread, exmem_rd!=0, and exmem_rd matches an enabled ID source. This yields a 2-cycle bubble because loads forward only from MEM/WB.
REQ-025 FSM states: RUN, I_HELD (fetch done, data pending), D_HELD (data done, fetch pending).
REQ-026 RUN, advance conditions: i_ok=imem_resp; d_ok=~dmem_req|dmem_resp; advance when both are 1.
REQ-027 RUN, i_ok & ~d_ok: capture imem_rdata into i_hold, go to I_HELD, freeze.
REQ-028 RUN, ~i_ok & dmem_req & dmem_resp: capture dmem_rdata into d_hold, go to D_HELD, freeze.
REQ-029 RUN, ~i_ok & ~d_ok: stay in RUN, freeze.
REQ-030 I_HELD: imem_req_en=0; on dmem_resp advance with if_instr=i_hold, then go to RUN.
REQ-031 D_HELD: dmem_req_en=0; on imem_resp advance with mem_rdata=d_hold, then go to RUN.
REQ-032 Otherwise if_instr=imem_rdata and mem_rdata=dmem_rdata; imem_req_en=(state!=I_HELD); dmem_req_en=dmem_req&(state!=D_HELD).
REQ-033 Freeze cycle: stage_load=5'b00000, flush=2'b00; br_redirect and lu are ignored until advance.
REQ-034 Advance cycles, in priority order:
- br_redirect: stage_load=5'b11111, flush=2'b11 (redirect beats lu).
- lu: stage_load=5'b00111, flush=2'b10.
- otherwise: stage_load=5'b11111, flush=2'b00.
REQ-035 All outputs except perf_cnt SHALL be combinational from state, hold registers and inputs; state and hold-register update latency is 1 cycle.

Reset
REQ-036 rst low SHALL force, asynchronously: state=RUN, i_hold=0, d_hold=0, all counters=0. This applies mid-stall; any pending cache response is discarded.
REQ-037 After reset deassertion the block SHALL behave as in RUN with no held data.

Configuration
REQ-038 With PIPELINE_CTRL_PERF_EN defined:
- lu_cnt increments on each advance cycle with lu & ~br_redirect.
- mem_cnt increments on each freeze cycle.
- flush_cnt increments on each advance cycle with br_redirect.
- Every counter saturates at all-ones.
REQ-039 Without PIPELINE_CTRL_PERF_EN: no counter flops; perf_cnt is tied to 0; the port is still present.

Verification
REQ-040 idex_memread=1, idex_rd=5, id_rs1=5, id_use=01, cache hits -> stage_load=00111 and flush=10 for 2 cycles (load in ID/EX, then in EX/MEM), then 11111.
REQ-041 Same as REQ-040 with idex_rd=0 -> no stall; stage_load=11111.
REQ-042 imem_resp at cycle 1 with imem_rdata 0x00A00093; dmem_req held; dmem_resp at cycle 3 with 0xDEADBEEF -> I_HELD in cycles 2-3, imem_req_en=0; cycle 3 advances with if_instr=0x00A00093 and mem_rdata=0xDEADBEEF.
REQ-043 dmem_resp at cycle 1 with 0x12345678; imem_resp at cycle 4 -> D_HELD, dmem_req_en=0, mem_cnt=3, advance with mem_rdata=0x12345678.
REQ-044 br_redirect=1 and lu=1 together with both caches ready -> stage_load=11111, flush=11, flush_cnt+1, lu_cnt unchanged.
REQ-045 rst low while in I_HELD -> next observation: state RUN, imem_req_en=1, if_instr follows imem_rdata, perf_cnt=0.
